imem_loader: RTL and testbench

Boot-time program loader that writes the instruction memory before the Tessia processor runs. It accepts a byte stream over a valid/ready handshake, checks the length, assembles little-endian 32-bit words, and writes them to consecutive word addresses. It validates the stream with an XOR checksum. It holds the processor in reset until a load completes cleanly. It is the write side of the instruction-memory port, which the processor only reads; it sits beside InstructionMemory in the top level.

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_loader_packer.sv | 47 ++++
 rtl/imem_loader.sv | 203 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the Tessia instruction-memory boot loader.
// Contents:
//   loader_state_t        loader FSM states
//   HDR_BYTES             bytes in the little-endian word-count header
//   BYTES_PER_WORD        bytes per instruction word
//   csum_fold()           one step of the running XOR checksum
package tessia_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;

  // Folds one stream byte into the running XOR checksum.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// byte_packer: assembles accepted stream bytes into a little-endian 32-bit
// word. Used for both the header count and the payload words.
// Ports:
//   clk, reset    clock, synchronous active-low reset
//   clr           synchronous clear of the byte counter and shift register
//   accept        a byte is consumed this cycle
//   data_in[7:0]  the byte being consumed
//   word[31:0]    assembled word, valid in the cycle word_done is high
//   word_done     the 4th byte of a word is being consumed this cycle
module byte_packer
  import tessia_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  data_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [31:0] shift_r;
  logic [1:0]  cnt_r;

  // The completing byte is merged combinationally so the word is usable in
  // the same cycle as its last byte; earlier bytes sit in shift_r[31:8].
  assign word      = {data_in, shift_r[31:8]};
  assign word_done = accept && (cnt_r == 2'(BYTES_PER_WORD - 1));

  // Shift register and byte counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_r <= 32'h0000_0000;
      cnt_r   <= 2'd0;
    end else if (clr) begin
      shift_r <= 32'h0000_0000;
      cnt_r   <= 2'd0;
    end else if (accept) begin
      shift_r <= {data_in, shift_r[31:8]};
      cnt_r   <= cnt_r + 2'd1;
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the Tessia instruction memory.
// Receives a byte stream (4-byte LE word count N, N LE words, XOR checksum
// byte), writes the words to consecutive word addresses and releases the
// processor only after a clean load.
// Ports:
//   clk, reset         clock, synchronous active-low reset
//   start              begin a load (honoured in IDLE, DONE, ERR)
//   rx_valid, rx_data  byte stream input
//   rx_ready           loader consumes a byte this cycle (state decode)
//   we, waddr, wdata   instruction-memory write port, one strobe per word
//   cpu_hold           processor reset request, high unless load succeeded
//   done, err          load outcome levels
//   words_loaded       words written in the current load
module imem_loader
  import tessia_loader_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       rx_ready,
  output logic                       we,
  output logic [31:0]                waddr,
  output logic [31:0]                wdata,
  output logic                       cpu_hold,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] words_loaded
);

  localparam int WL_W = $clog2(DEPTH + 1);

  loader_state_t state_r, state_next_s;

  logic            accept_s;
  logic            start_load_s;
  logic            pack_accept_s;
  logic            word_done_s;
  logic [31:0]     word_s;
  logic            last_word_s;
  logic            write_s;
  logic [31:0]     count_r;
  logic [7:0]      xor_r;
  logic            we_r;
  logic [31:0]     waddr_r;
  logic [31:0]     wdata_r;
  logic            done_r;
  logic            err_r;
  logic            hold_r;
  logic [WL_W-1:0] words_r;

  assign rx_ready      = (state_r == HDR) || (state_r == DATA) || (state_r == CSUM);
  assign accept_s      = rx_valid && rx_ready;
  // The checksum byte is not part of any word, so keep it out of the packer.
  assign pack_accept_s = accept_s && ((state_r == HDR) || (state_r == DATA));
  // Earlier words have already bumped words_r, so it is the index of the
  // word completing now.
  assign last_word_s   = (32'(words_r) == (count_r - 32'd1));
  assign write_s       = (state_r == DATA) && word_done_s;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (start_load_s),
    .accept    (pack_accept_s),
    .data_in   (rx_data),
    .word      (word_s),
    .word_done (word_done_s)
  );

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    start_load_s = 1'b0;
    case (state_r)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_next_s = HDR;
          start_load_s = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      HDR: begin
        if (word_done_s) begin
          if (word_s > 32'(DEPTH)) begin
            state_next_s = ERR;
          end else if (word_s == 32'd0) begin
            state_next_s = CSUM;
          end else begin
            state_next_s = DATA;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      DATA: begin
        if (word_done_s && last_word_s) begin
          state_next_s = CSUM;
        end else begin
          state_next_s = state_r;
        end
      end
      CSUM: begin
        if (accept_s) begin
          // xor_r holds the XOR of all bytes before this one.
          if (rx_data == xor_r) begin
            state_next_s = DONE;
          end else begin
            state_next_s = ERR;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Checksum accumulator and header count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      xor_r   <= 8'h00;
      count_r <= 32'h0000_0000;
    end else begin
      if (start_load_s) begin
        xor_r <= 8'h00;
      end else if (accept_s) begin
        xor_r <= csum_fold(xor_r, rx_data);
      end else begin
        xor_r <= xor_r;
      end
      if ((state_r == HDR) && word_done_s) begin
        count_r <= word_s;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Write port and word counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      we_r    <= 1'b0;
      waddr_r <= BASE_ADDR;
      wdata_r <= 32'h0000_0000;
      words_r <= '0;
    end else begin
      we_r <= write_s;
      if (write_s) begin
        waddr_r <= BASE_ADDR + (32'(words_r) << 2);
        wdata_r <= word_s;
      end else begin
        waddr_r <= waddr_r;
        wdata_r <= wdata_r;
      end
      if (start_load_s) begin
        words_r <= '0;
      end else if (write_s) begin
        words_r <= words_r + WL_W'(1);
      end else begin
        words_r <= words_r;
      end
    end
  end

  // Outcome flags follow the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      hold_r <= 1'b1;
    end else begin
      done_r <= (state_next_s == DONE);
      err_r  <= (state_next_s == ERR);
      hold_r <= (state_next_s != DONE);
    end
  end

  assign we           = we_r;
  assign waddr        = waddr_r;
  assign wdata        = wdata_r;
  assign done         = done_r;
  assign err          = err_r;
  assign cpu_hold     = hold_r;
  assign words_loaded = words_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: reference model builds each stream
// and the expected write list from the stream format rules.
module tb_imem_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          WLW   = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_ready;
  logic            we;
  logic [31:0]     waddr;
  logic [31:0]     wdata;
  logic            cpu_hold;
  logic            done;
  logic            err;
  logic [WLW-1:0]  words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wq[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];

  typedef struct {
    logic [31:0] hdr;
    int          gap;
    logic        bad;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) begin
      got_addr.push_back(waddr);
      got_data.push_back(wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offers one byte after gap idle cycles; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap, input logic word_end);
    int cnt;
    rx_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    cnt = 0;
    while (!rx_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!rx_ready) begin
      check("rx_ready_timeout", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check("we_timing", 32'(we), 32'(word_end));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full load of wq behind header hdr; model derives checksum and writes.
  task automatic run_load(input string tag, input logic [31:0] hdr, input int gap,
                          input logic bad, input logic csum_en, input logic [7:0] csum_val,
                          input logic exp_done, input logic exp_err);
    logic [7:0]  x;
    logic [7:0]  cs;
    logic [31:0] w;
    logic        fits;
    int          nexp;
    got_addr.delete();
    got_data.delete();
    fits = (hdr <= 32'(DEPTH));
    pulse_start();
    check({tag, ":hold_in_load"}, 32'(cpu_hold), 32'd1);
    check({tag, ":done_in_load"}, 32'(done), 32'd0);
    check({tag, ":wl_cleared"}, 32'(words_loaded), 32'd0);
    x = 8'h00;
    for (int i = 0; i < 4; i++) begin
      x = x ^ hdr[8*i +: 8];
      send_byte(hdr[8*i +: 8], gap, 1'b0);
    end
    if (fits) begin
      for (int k = 0; k < wq.size(); k++) begin
        w = wq[k];
        for (int j = 0; j < 4; j++) begin
          x = x ^ w[8*j +: 8];
          send_byte(w[8*j +: 8], gap, j == 3);
        end
      end
      cs = csum_en ? csum_val : (bad ? (x ^ 8'h01) : x);
      send_byte(cs, gap, 1'b0);
    end
    check({tag, ":done"}, 32'(done), 32'(exp_done));
    check({tag, ":err"}, 32'(err), 32'(exp_err));
    check({tag, ":cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check({tag, ":rx_ready"}, 32'(rx_ready), 32'd0);
    nexp = fits ? wq.size() : 0;
    check({tag, ":words_loaded"}, 32'(words_loaded), 32'(nexp));
    check({tag, ":n_writes"}, 32'(got_addr.size()), 32'(nexp));
    if (got_addr.size() == nexp) begin
      for (int k = 0; k < nexp; k++) begin
        check({tag, ":waddr"}, got_addr[k], BASE + 32'(4 * k));
        check({tag, ":wdata"}, got_data[k], wq[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ":rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, ":we"}, 32'(we), 32'd0);
    check({tag, ":waddr"}, waddr, BASE);
    check({tag, ":wdata"}, wdata, 32'd0);
    check({tag, ":cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, ":done"}, 32'(done), 32'd0);
    check({tag, ":err"}, 32'(err), 32'd0);
    check({tag, ":words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    vecs[0] = '{hdr: 32'd0,          gap: 0, bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{hdr: 32'd1,          gap: 2, bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{hdr: 32'd3,          gap: 1, bad: 1'b1, exp_done: 1'b0, exp_err: 1'b1};
    vecs[3] = '{hdr: 32'd256,        gap: 0, bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{hdr: 32'd257,        gap: 0, bad: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[5] = '{hdr: 32'hFFFF_FFFF,  gap: 1, bad: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[6] = '{hdr: 32'h0001_0001,  gap: 0, bad: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[7] = '{hdr: 32'd0,          gap: 0, bad: 1'b1, exp_done: 1'b0, exp_err: 1'b1};

    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clk);
    check("idle_rx_ready", 32'(rx_ready), 32'd0);

    // Normal load from the reference stream.
    wq = '{32'h1122_3344, 32'hAABB_CCDD};
    run_load("normal", 32'd2, 0, 1'b0, 1'b1, 8'h46, 1'b1, 1'b0);
    run_load("gapped", 32'd2, 3, 1'b0, 1'b1, 8'h46, 1'b1, 1'b0);
    run_load("badcs", 32'd2, 0, 1'b0, 1'b1, 8'h47, 1'b0, 1'b1);
    wq.delete();
    run_load("empty", 32'd0, 0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    run_load("over257", 32'd257, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset after the 6th byte: partial word must never be written.
    got_addr.delete();
    got_data.delete();
    pulse_start();
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h44, 0, 1'b0);
    send_byte(8'h33, 0, 1'b0);
    reset = 1'b0;
    start = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h22;
    @(negedge clk);
    check_reset_values("midreset");
    @(negedge clk);
    check("midreset_start_ignored", 32'(rx_ready), 32'd0);
    reset = 1'b1;
    start = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    check("midreset_idle", 32'(rx_ready), 32'd0);
    check("midreset_no_we", 32'(got_addr.size()), 32'd0);

    // Reload after a successful load.
    wq = '{32'h1122_3344, 32'hAABB_CCDD};
    run_load("normal2", 32'd2, 0, 1'b0, 1'b1, 8'h46, 1'b1, 1'b0);
    wq = '{32'hDEAD_BEEF};
    run_load("reload", 32'd1, 0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Table-driven corner headers with random payloads.
    for (int v = 0; v < 8; v++) begin
      wq.delete();
      if (vecs[v].hdr <= 32'(DEPTH)) begin
        for (int k = 0; k < int'(vecs[v].hdr); k++) wq.push_back($urandom);
      end
      run_load($sformatf("vec%0d", v), vecs[v].hdr, vecs[v].gap, vecs[v].bad,
               1'b0, 8'h00, vecs[v].exp_done, vecs[v].exp_err);
    end

    // Random loads.
    for (int r = 0; r < 20; r++) begin
      int   n;
      int   g;
      logic b;
      n = $urandom_range(0, 5);
      g = $urandom_range(0, 2);
      b = ($urandom_range(0, 3) == 0);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back($urandom);
      run_load($sformatf("rand%0d", r), 32'(n), g, b, 1'b0, 8'h00, !b, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
